// File: rtl/input_detect_multi_if.sv
// input_detect_multi_if: control, raw input and result bundle for the multi-channel input detector
// master drives enable/edge_mode/signal_i; slave drives level_o/pulse_o and the summary outputs
interface input_detect_multi_if #(
    parameter int N_CH = 9
) ();
    localparam int IDX_W = N_CH > 1 ? $clog2(N_CH) : 1;
    logic              enable;
    logic [1:0]        edge_mode;
    logic [N_CH-1:0]   signal_i;
    logic [N_CH-1:0]   level_o;
    logic [N_CH-1:0]   pulse_o;
    logic              any_pulse_o;
    logic              multi_o;
    logic [IDX_W-1:0]  ch_idx_o;
    modport master (
        output enable, edge_mode, signal_i,
        input  level_o, pulse_o, any_pulse_o, multi_o, ch_idx_o
    );
    modport slave (
        input  enable, edge_mode, signal_i,
        output level_o, pulse_o, any_pulse_o, multi_o, ch_idx_o
    );
endinterface

// File: rtl/input_detect_multi.sv
// input_detect_multi: per-channel synchronise, debounce and edge-detect with pulse summary
// clk, rst       : clock and synchronous active-high reset
// bus.enable     : pulses allowed when high; filtering always runs
// bus.edge_mode  : 00 rise, 01 fall, 10 both, 11 none
// bus.signal_i   : raw asynchronous inputs
// bus.level_o    : debounced levels
// bus.pulse_o    : one-cycle pulse per qualifying debounced edge
// bus.any_pulse_o, bus.multi_o, bus.ch_idx_o : OR, two-or-more flag, lowest pulsing index
module input_detect_multi #(
    parameter int N_CH            = 9,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input logic                clk,
    input logic                rst,
    input_detect_multi_if.slave bus
);
    localparam int CNT_W = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int IDX_W = N_CH > 1 ? $clog2(N_CH) : 1;
    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_q  [N_CH];
    logic [CNT_W-1:0] cnt_d  [N_CH];
    logic [N_CH-1:0]  s;
    logic [N_CH-1:0]  flip;
    logic [N_CH-1:0]  pulse_d;
    logic [IDX_W-1:0] idx_d;
    assign s = sync_q[SYNC_STAGES-1];
    always_comb begin
        flip = '0;
        cnt_d = '{default: '0};
        for (int i = 0; i < N_CH; i++) begin
            flip[i] = s[i] != bus.level_o[i] && cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1);
            cnt_d[i] = (s[i] == bus.level_o[i] || flip[i]) ? '0 : cnt_q[i] + 1'b1;
        end
        // after a flip the new level equals s, so flip & s is a rise and flip & ~s a fall
        pulse_d = !bus.enable           ? '0 :
                  bus.edge_mode == 2'b00 ? flip & s :
                  bus.edge_mode == 2'b01 ? flip & ~s :
                  bus.edge_mode == 2'b10 ? flip : '0;
        idx_d = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (pulse_d[i]) idx_d = IDX_W'(i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q          <= '{default: '0};
            cnt_q           <= '{default: '0};
            bus.level_o     <= '0;
            bus.pulse_o     <= '0;
            bus.any_pulse_o <= 1'b0;
            bus.multi_o     <= 1'b0;
            bus.ch_idx_o    <= '0;
        end else begin
            sync_q[0] <= bus.signal_i;
            for (int k = 1; k < SYNC_STAGES; k++)
                sync_q[k] <= sync_q[k-1];
            cnt_q           <= cnt_d;
            bus.level_o     <= bus.level_o ^ flip;
            bus.pulse_o     <= pulse_d;
            bus.any_pulse_o <= |pulse_d;
            // clearing the lowest set bit leaves something only if two or more were set
            bus.multi_o     <= (pulse_d & (pulse_d - 1'b1)) != '0;
            bus.ch_idx_o    <= idx_d;
        end
    end
endmodule
